// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: shared opcode, funct codes and ALU operation encoding for the execute pipeline
package rv_alu_pkg;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
endpackage

// File: rtl/rv_alu_pipe_core.sv
// rv_alu_core: combinational XLEN-wide integer ALU with zero flag
module rv_alu_core
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] y,
  output logic            zero
);
  localparam int SW = $clog2(XLEN);
  logic signed [XLEN-1:0] sa, sb;
  logic [SW-1:0] sh;
  logic [XLEN-1:0] sra;
  assign sa = a;
  assign sb = b;
  assign sh = b[SW-1:0];
  assign sra = sa >>> sh;
  // select the operation result; comparisons yield a zero-extended 0/1
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, sa < sb};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = sra;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end
  assign zero = y == '0;
endmodule

// File: rtl/rv_alu_pipe.sv
// rv_alu_pipe: 3-stage ID/EX/WB integer pipeline with forwarding, hold and illegal detection
module rv_alu_pipe
  import rv_alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            hold,
  output logic            res_valid,
  output logic [4:0]      res_rd,
  output logic [XLEN-1:0] res_data,
  output logic            res_zero,
  output logic            res_illegal
);
  localparam logic [5:0] NR = 6'(NREGS);
  logic [31:0] id_instr;
  logic id_valid;
  logic [XLEN-1:0] ex_a, ex_b;
  alu_op_t ex_op;
  logic [4:0] ex_rd;
  logic ex_ill, ex_valid;
  logic [XLEN-1:0] wb_res;
  logic [4:0] wb_rd;
  logic wb_ill, wb_valid, wb_zero;
  logic [XLEN-1:0] rf [32];
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic [XLEN-1:0] imm, src1, src2, opb, alu_y;
  logic alu_zero, is_r, is_i, shift_ok, r_ok, i_ok, idx_ok, legal, ex_fw, wb_fw;
  alu_op_t dec_op;
  assign opc = id_instr[6:0];
  assign rd  = id_instr[11:7];
  assign f3  = id_instr[14:12];
  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];
  assign f7  = id_instr[31:25];
  assign imm = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
  assign is_r = opc == OP_R;
  assign is_i = opc == OP_IMM;
  assign shift_ok = XLEN == 64
    ? (id_instr[31:26] == 6'b0 || (f3 == F3_SR && id_instr[31:26] == 6'b010000))
    : (f7 == 7'b0 || (f3 == F3_SR && f7 == F7_ALT));
  assign r_ok = f7 == 7'b0 || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
  assign i_ok = (f3 == F3_SLL || f3 == F3_SR) ? shift_ok : 1'b1;
  assign idx_ok = {1'b0, rd} < NR && {1'b0, rs1} < NR && (!is_r || {1'b0, rs2} < NR);
  assign legal = ((is_r && r_ok) || (is_i && i_ok)) && idx_ok;
  // map funct3 (plus the alternate bit) onto an ALU operation
  always_comb begin
    dec_op = ALU_ADD;
    case (f3)
      F3_ADD:  dec_op = (is_r && id_instr[30]) ? ALU_SUB : ALU_ADD;
      F3_SLL:  dec_op = ALU_SLL;
      F3_SLT:  dec_op = ALU_SLT;
      F3_SLTU: dec_op = ALU_SLTU;
      F3_XOR:  dec_op = ALU_XOR;
      F3_SR:   dec_op = id_instr[30] ? ALU_SRA : ALU_SRL;
      F3_OR:   dec_op = ALU_OR;
      F3_AND:  dec_op = ALU_AND;
      default: dec_op = ALU_ADD;
    endcase
  end
  assign ex_fw = ex_valid && !ex_ill && ex_rd != 5'd0;
  assign wb_fw = wb_valid && !wb_ill && wb_rd != 5'd0;
  assign src1 = (ex_fw && ex_rd == rs1) ? alu_y : (wb_fw && wb_rd == rs1) ? wb_res : rf[rs1];
  assign src2 = (ex_fw && ex_rd == rs2) ? alu_y : (wb_fw && wb_rd == rs2) ? wb_res : rf[rs2];
  assign opb = is_r ? src2 : imm;
  rv_alu_core #(.XLEN(XLEN)) u_alu (
    .a(ex_a), .b(ex_b), .op(ex_op), .y(alu_y), .zero(alu_zero)
  );
  // advance all three stages together unless held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_instr <= '0;
      id_valid <= 1'b0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_op    <= ALU_ADD;
      ex_rd    <= '0;
      ex_ill   <= 1'b0;
      ex_valid <= 1'b0;
      wb_res   <= '0;
      wb_zero  <= 1'b1;
      wb_rd    <= '0;
      wb_ill   <= 1'b0;
      wb_valid <= 1'b0;
    end else if (!hold) begin
      id_instr <= in_instr;
      id_valid <= in_valid;
      ex_a     <= src1;
      ex_b     <= opb;
      ex_op    <= dec_op;
      ex_rd    <= rd;
      ex_ill   <= !legal;
      ex_valid <= id_valid;
      wb_res   <= alu_y;
      wb_zero  <= alu_zero;
      wb_rd    <= ex_rd;
      wb_ill   <= ex_ill;
      wb_valid <= ex_valid;
    end
  end
  // commit the WB result; x0 and illegal instructions never write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!hold && wb_fw) begin
      rf[wb_rd] <= wb_res;
    end
  end
  assign in_ready    = !hold;
  assign res_valid   = wb_valid;
  assign res_rd      = wb_rd;
  assign res_data    = wb_res;
  assign res_zero    = wb_zero;
  assign res_illegal = wb_valid && wb_ill;
endmodule

// File: tb/tb_rv_alu_pipe.sv
// tb_rv_alu_pipe: directed and random checks of the execute pipeline against an in-order ISS
module tb_rv_alu_pipe;
  typedef logic [31:0] rf_t [32];
  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } exp_t;
  logic clk, rst, in_valid, hold, in_ready, in_ready16;
  logic [31:0] in_instr;
  logic res_valid, res_zero, res_illegal, res_valid16, res_zero16, res_illegal16;
  logic [4:0] res_rd, res_rd16;
  logic [31:0] res_data, res_data16;
  int ncmp = 0, nfail = 0, adv = 0;
  rf_t rf32, rf16;
  exp_t q32[$], q16[$];
  logic [31:0] log_q[$];
  rv_alu_pipe #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .hold(hold), .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
    .res_zero(res_zero), .res_illegal(res_illegal)
  );
  rv_alu_pipe #(.XLEN(32), .NREGS(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_instr(in_instr),
    .hold(hold), .res_valid(res_valid16), .res_rd(res_rd16), .res_data(res_data16),
    .res_zero(res_zero16), .res_illegal(res_illegal16)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction
  function automatic logic is_legal(input logic [31:0] ins, input int nr);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    if (ins[6:0] == 7'h33)
      return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
             && int'(ins[11:7]) < nr && int'(ins[19:15]) < nr && int'(ins[24:20]) < nr;
    if (ins[6:0] == 7'h13) begin
      if (f3 == 3'd1 && f7 != 7'h00) return 1'b0;
      if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return 1'b0;
      return int'(ins[11:7]) < nr && int'(ins[19:15]) < nr;
    end
    return 1'b0;
  endfunction
  function automatic logic [31:0] ref_alu(input logic [31:0] ins, input logic [31:0] a, b);
    logic [4:0] s;
    s = b[4:0];
    case (ins[14:12])
      3'd0: return (ins[6:0] == 7'h33 && ins[30]) ? a - b : a + b;
      3'd1: return a << s;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (ins[30]) return $signed(a) >>> s;
        return a >> s;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction
  function automatic exp_t iss(input logic [31:0] ins, input int nr, input rf_t r);
    exp_t e;
    logic [31:0] a, b;
    a = r[ins[19:15]];
    b = (ins[6:0] == 7'h33) ? r[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
    e.due = adv + 3;
    e.rd = ins[11:7];
    e.ill = !is_legal(ins, nr);
    e.data = ref_alu(ins, a, b);
    return e;
  endfunction
  task automatic model_accept(input logic [31:0] ins);
    exp_t e;
    e = iss(ins, 32, rf32);
    q32.push_back(e);
    if (!e.ill && e.rd != 5'd0) rf32[e.rd] = e.data;
    e = iss(ins, 16, rf16);
    q16.push_back(e);
    if (!e.ill && e.rd != 5'd0) rf16[e.rd] = e.data;
  endtask
  task automatic check_res(input int w, input logic v, input logic [4:0] rd,
                           input logic [31:0] d, input logic z, input logic il);
    exp_t e;
    logic ev;
    ev = 1'b0;
    if (w == 0 && q32.size() > 0 && q32[0].due == adv) begin ev = 1'b1; e = q32.pop_front(); end
    if (w == 1 && q16.size() > 0 && q16[0].due == adv) begin ev = 1'b1; e = q16.pop_front(); end
    chk($sformatf("res_valid[n%0d]", w), 32'(v), 32'(ev));
    if (ev) begin
      chk($sformatf("res_rd[n%0d]", w), 32'(rd), 32'(e.rd));
      chk($sformatf("res_illegal[n%0d]", w), 32'(il), 32'(e.ill));
      if (!e.ill) begin
        chk($sformatf("res_data[n%0d]", w), d, e.data);
        chk($sformatf("res_zero[n%0d]", w), 32'(z), 32'(e.data == 32'd0));
        if (w == 0) log_q.push_back(d);
      end
    end
  endtask
  task automatic step(input logic v, input logic [31:0] ins, input logic h);
    logic sv, si, sz;
    logic [4:0] sr;
    logic [31:0] sd;
    in_valid = v;
    in_instr = ins;
    hold = h;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!h));
    chk("in_ready16", 32'(in_ready16), 32'(!h));
    {sv, si, sz, sr, sd} = {res_valid, res_illegal, res_zero, res_rd, res_data};
    if (v && !h) model_accept(ins);
    @(posedge clk);
    #1;
    if (h) begin
      chk("hold_valid", 32'(res_valid), 32'(sv));
      chk("hold_rd", 32'(res_rd), 32'(sr));
      chk("hold_data", res_data, sd);
      chk("hold_zero", 32'(res_zero), 32'(sz));
      chk("hold_illegal", 32'(res_illegal), 32'(si));
    end else begin
      adv++;
      check_res(0, res_valid, res_rd, res_data, res_zero, res_illegal);
      check_res(1, res_valid16, res_rd16, res_data16, res_zero16, res_illegal16);
    end
  endtask
  task automatic send(input logic [31:0] ins);
    step(1'b1, ins, 1'b0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0);
  endtask
  task automatic chk_log(input string tag, input int back, input logic [31:0] exp);
    logic [31:0] v;
    v = (log_q.size() > back) ? log_q[log_q.size() - 1 - back] : 32'hxxxx_xxxx;
    chk(tag, v, exp);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_rd"}, 32'(res_rd), 32'd0);
    chk({tag, "_data"}, res_data, 32'd0);
    chk({tag, "_zero"}, 32'(res_zero), 32'd1);
    chk({tag, "_illegal"}, 32'(res_illegal), 32'd0);
    chk({tag, "_valid16"}, 32'(res_valid16), 32'd0);
  endtask
  function automatic logic [31:0] gen();
    logic [31:0] w;
    logic [11:0] imm;
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    int k;
    k = $urandom_range(0, 19);
    rd = 5'($urandom_range(0, 19));
    rs1 = 5'($urandom_range(0, 19));
    rs2 = 5'($urandom_range(0, 19));
    f3 = 3'($urandom_range(0, 7));
    w = $urandom;
    if (k < 9) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return r_ins(f7, rs2, rs1, f3, rd);
    end
    if (k < 18) begin
      imm = w[11:0];
      if (f3 == 3'd1) imm[11:5] = 7'h00;
      if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return i_ins(imm, rs1, f3, rd);
    end
    return w;
  endfunction
  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    hold = 1'b0;
    in_instr = 32'd0;
    for (int i = 0; i < 32; i++) begin rf32[i] = 32'd0; rf16[i] = 32'd0; end
    @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;
    // back-to-back EX forwarding
    send(i_ins(12'd5, 5'd0, 3'd0, 5'd1));
    send(i_ins(12'd7, 5'd1, 3'd0, 5'd2));
    send(r_ins(7'h20, 5'd1, 5'd2, 3'd0, 5'd3));
    idle(2);
    chk_log("b2b_addi", 2, 32'd5);
    chk_log("b2b_addi_fwd", 1, 32'd12);
    chk_log("b2b_sub", 0, 32'd7);
    // gap-of-one WB forwarding and shifts
    send(i_ins(12'hFFF, 5'd0, 3'd0, 5'd1));
    idle(1);
    send(i_ins(12'h404, 5'd1, 3'd5, 5'd2));
    send(i_ins(12'd28, 5'd1, 3'd5, 5'd2));
    send(r_ins(7'h00, 5'd1, 5'd0, 3'd3, 5'd3));
    idle(2);
    chk_log("srai", 2, 32'hFFFF_FFFF);
    chk_log("srli", 1, 32'h0000_000F);
    chk_log("sltu", 0, 32'd1);
    // x0 discard and illegal not forwarded
    send(i_ins(12'd9, 5'd0, 3'd0, 5'd0));
    send(r_ins(7'h00, 5'd0, 5'd0, 3'd0, 5'd1));
    send(i_ins(12'd33, 5'd0, 3'd0, 5'd5));
    send(32'h0000_02FF);
    send(r_ins(7'h00, 5'd0, 5'd5, 3'd0, 5'd6));
    idle(2);
    chk_log("addi_x0_result", 3, 32'd9);
    chk_log("x0_reads_zero", 2, 32'd0);
    chk_log("illegal_skipped", 0, 32'd33);
    // reset with instructions in flight
    send(i_ins(12'd1, 5'd0, 3'd0, 5'd7));
    send(i_ins(12'd2, 5'd0, 3'd0, 5'd8));
    rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    q32.delete();
    q16.delete();
    for (int i = 0; i < 32; i++) begin rf32[i] = 32'd0; rf16[i] = 32'd0; end
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    idle(2);
    chk_log("post_reset_add", 0, 32'd0);
    // register index out of range for the 16-register variant
    send(i_ins(12'd3, 5'd0, 3'd0, 5'd1));
    send(r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd17));
    idle(2);
    chk("x17_illegal_n16", 32'(res_illegal16), 32'd1);
    chk("x17_legal_n32", 32'(res_illegal), 32'd0);
    // hold mid-stream
    send(i_ins(12'd11, 5'd0, 3'd0, 5'd9));
    send(r_ins(7'h00, 5'd9, 5'd9, 3'd0, 5'd10));
    for (int i = 0; i < 3; i++) step(1'b1, i_ins(12'd1, 5'd10, 3'd0, 5'd11), 1'b1);
    send(r_ins(7'h20, 5'd9, 5'd10, 3'd0, 5'd12));
    idle(3);
    chk_log("post_hold_sub", 0, 32'd11);
    // random stream, both register-count variants against the ISS
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 9) < 8, gen(), $urandom_range(0, 19) == 0);
    idle(4);
    chk("drain_n32", q32.size(), 32'd0);
    chk("drain_n16", q16.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
